hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 21 ++
 rtl/sat_counter16.sv | 29 ++
 rtl/hazard_unit.sv | 109 ++++++++++
 tb/tb_hazard_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit_pkg
//  Purpose  : Shared pipeline definitions for the hazard unit: FSM state
//             encoding, default double-precision FP EX latency, and the
//             register-index width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package hazard_unit_pkg;

   localparam int REGW                = 5;
   localparam int FP_DBL_LAT_DEFAULT  = 3;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      FP_WAIT = 1'b1
   } hu_state_t;

endpackage : hazard_unit_pkg
`default_nettype wire

// File: rtl/sat_counter16.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter16
//  Purpose  : 16-bit up-counter with enable that sticks at 16'hFFFF.
//  Ports    : clk   - clock
//             rst   - asynchronous active-high reset (clears count)
//             en    - count enable, one increment per rising edge
//             count - current count value
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] count
);

   localparam logic [15:0] c_MAX = 16'hFFFF;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 16'h0000;
      end else if (en && (count != c_MAX)) begin
         count <= count + 16'h0001;
      end
   end

endmodule : sat_counter16
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : Pipeline hazard detection. Stalls ID for one cycle on a
//             load-use dependency, holds ID for FP_DBL_LAT-1 cycles behind a
//             double-precision FP op in EX, and squashes IF/ID on taken
//             branches/jumps when not stalled.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             id_rs, id_rt        - source register fields of ID instruction
//             id_rt_is_src        - ID instruction reads rt
//             ex_mem_read, ex_dst - load indicator / destination of EX instr
//             ex_floatop,ex_double- EX instruction is a double FP op
//             branch_taken, jump  - control transfer resolved in ID
//             Stall               - bubble request to control unit
//             PCWrite, IFIDWrite  - PC / IF-ID write enables
//             IFIDFlush           - squash fetched instruction
//             fp_busy             - double FP op occupying EX
//             stall_count         - saturating stalled-cycle count
//  Revision : 1.0  initial release
// ============================================================================
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int FP_DBL_LAT = FP_DBL_LAT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [REGW-1:0] id_rs,
   input  logic [REGW-1:0] id_rt,
   input  logic            id_rt_is_src,
   input  logic            ex_mem_read,
   input  logic [REGW-1:0] ex_dst,
   input  logic            ex_floatop,
   input  logic            ex_double,
   input  logic            branch_taken,
   input  logic            jump,
   output logic            Stall,
   output logic            PCWrite,
   output logic            IFIDWrite,
   output logic            IFIDFlush,
   output logic            fp_busy,
   output logic [15:0]     stall_count
);

   // Counter preload: FP_DBL_LAT-2 down to 0 inclusive = FP_DBL_LAT-1 stalls.
   localparam logic [3:0] c_FP_LOAD = 4'(FP_DBL_LAT - 2);

   hu_state_t  r_state;
   logic [3:0] r_fp_cnt;

   logic w_idle;
   logic w_load_use;
   logic w_fp_trig;

   assign w_idle = (r_state == IDLE);

   // Writes to r0 never create a dependency.
   assign w_load_use = w_idle && ex_mem_read && (ex_dst != '0) &&
                       ((ex_dst == id_rs) || (id_rt_is_src && (ex_dst == id_rt)));

   // Loads/stores of doubles go through the load-use path, not the FP wait.
   assign w_fp_trig  = w_idle && ex_floatop && ex_double && !ex_mem_read;

   assign Stall      = !w_idle || w_load_use;
   assign PCWrite    = !Stall;
   assign IFIDWrite  = !Stall;
   // A flush during a stall is dropped; the branch re-resolves once ID moves.
   assign IFIDFlush  = (branch_taken || jump) && !Stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_fp_cnt <= 4'd0;
         fp_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_fp_trig) begin
                  r_state  <= FP_WAIT;
                  r_fp_cnt <= c_FP_LOAD;
                  fp_busy  <= 1'b1;
               end
            end
            FP_WAIT: begin
               if (r_fp_cnt == 4'd0) begin
                  r_state <= IDLE;
                  fp_busy <= 1'b0;
               end else begin
                  r_fp_cnt <= r_fp_cnt - 4'd1;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_fp_cnt <= 4'd0;
               fp_busy  <= 1'b0;
            end
         endcase
      end
   end

   sat_counter16 u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (Stall),
      .count (stall_count)
   );

endmodule : hazard_unit
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit
//  Purpose  : Directed self-checking bench for hazard_unit (FP_DBL_LAT=3).
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs, id_rt, ex_dst;
   logic        id_rt_is_src, ex_mem_read, ex_floatop, ex_double;
   logic        branch_taken, jump;
   logic        Stall, PCWrite, IFIDWrite, IFIDFlush, fp_busy;
   logic [15:0] stall_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_unit #(.FP_DBL_LAT(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rt_is_src (id_rt_is_src),
      .ex_mem_read  (ex_mem_read),
      .ex_dst       (ex_dst),
      .ex_floatop   (ex_floatop),
      .ex_double    (ex_double),
      .branch_taken (branch_taken),
      .jump         (jump),
      .Stall        (Stall),
      .PCWrite      (PCWrite),
      .IFIDWrite    (IFIDWrite),
      .IFIDFlush    (IFIDFlush),
      .fp_busy      (fp_busy),
      .stall_count  (stall_count)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_rt_is_src = 1'b0;
      ex_mem_read = 1'b0; ex_dst = 5'd0; ex_floatop = 1'b0; ex_double = 1'b0;
      branch_taken = 1'b0; jump = 1'b0;
   endtask

   // Advance one clock: passes a rising edge, lands on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      #1;
      check("rst_stall",   {15'd0, Stall},   16'd0);
      check("rst_pcwrite", {15'd0, PCWrite}, 16'd1);
      check("rst_fpbusy",  {15'd0, fp_busy}, 16'd0);
      check("rst_count",   stall_count,      16'd0);
      tick();
      rst = 1'b0;

      // Load-use on rs: one stall cycle.
      ex_mem_read = 1'b1; ex_dst = 5'd8; id_rs = 5'd8; #1;
      check("lu_stall",     {15'd0, Stall},     16'd1);
      check("lu_pcwrite",   {15'd0, PCWrite},   16'd0);
      check("lu_ifidwrite", {15'd0, IFIDWrite}, 16'd0);
      tick();
      clear_inputs(); #1;
      check("lu_release", {15'd0, Stall}, 16'd0);
      check("lu_count",   stall_count,    16'd1);

      // r0 destination never stalls; rt match only counts if rt is a source.
      ex_mem_read = 1'b1; ex_dst = 5'd0; id_rs = 5'd0; #1;
      check("r0_nostall", {15'd0, Stall}, 16'd0);
      ex_dst = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_rt_is_src = 1'b0; #1;
      check("rt_notsrc", {15'd0, Stall}, 16'd0);
      id_rt_is_src = 1'b1; branch_taken = 1'b1; #1;
      check("rt_src_stall",   {15'd0, Stall},     16'd1);
      check("flush_suppress", {15'd0, IFIDFlush}, 16'd0);
      tick();
      ex_mem_read = 1'b0; #1;
      check("flush_after", {15'd0, IFIDFlush}, 16'd1);
      check("count2",      stall_count,        16'd2);
      tick();
      branch_taken = 1'b0; #1;
      check("flush_drop", {15'd0, IFIDFlush}, 16'd0);
      jump = 1'b1; #1;
      check("jump_flush", {15'd0, IFIDFlush}, 16'd1);
      jump = 1'b0;

      // Asynchronous reset clears the count mid-cycle.
      rst = 1'b1; #1;
      check("arst_count", stall_count, 16'd0);
      rst = 1'b0;
      tick();

      // Double FP op in EX: entry cycle does not stall, then 2 stall cycles.
      ex_floatop = 1'b1; ex_double = 1'b1; #1;
      check("fp_entry_stall", {15'd0, Stall},   16'd0);
      check("fp_entry_busy",  {15'd0, fp_busy}, 16'd0);
      tick();
      // Inputs ignored while waiting, including a would-be load-use and branch.
      clear_inputs();
      ex_mem_read = 1'b1; ex_dst = 5'd4; id_rs = 5'd7; branch_taken = 1'b1;
      ex_floatop = 1'b1; ex_double = 1'b1; #1;
      check("fp1_stall", {15'd0, Stall},     16'd1);
      check("fp1_busy",  {15'd0, fp_busy},   16'd1);
      check("fp1_flush", {15'd0, IFIDFlush}, 16'd0);
      check("fp1_pcw",   {15'd0, PCWrite},   16'd0);
      tick();
      clear_inputs(); #1;
      check("fp2_stall", {15'd0, Stall},   16'd1);
      check("fp2_busy",  {15'd0, fp_busy}, 16'd1);
      check("fp2_count", stall_count,      16'd1);
      tick();
      check("fp_done_stall", {15'd0, Stall},   16'd0);
      check("fp_done_busy",  {15'd0, fp_busy}, 16'd0);
      check("fp_done_count", stall_count,      16'd2);

      // FP double load follows load-use only.
      ex_floatop = 1'b1; ex_double = 1'b1; ex_mem_read = 1'b1;
      ex_dst = 5'd5; id_rs = 5'd6; #1;
      check("fpld_nostall", {15'd0, Stall}, 16'd0);
      tick();
      clear_inputs(); #1;
      check("fpld_nobusy", {15'd0, fp_busy}, 16'd0);
      check("fpld_idle",   {15'd0, Stall},   16'd0);

      // Reset pulse on first FP_WAIT cycle aborts the wait.
      ex_floatop = 1'b1; ex_double = 1'b1;
      tick();
      clear_inputs(); #1;
      check("abort_pre_stall", {15'd0, Stall}, 16'd1);
      rst = 1'b1; #1;
      check("abort_stall", {15'd0, Stall},   16'd0);
      check("abort_busy",  {15'd0, fp_busy}, 16'd0);
      check("abort_count", stall_count,      16'd0);
      rst = 1'b0;
      tick();
      check("abort_after_stall", {15'd0, Stall},   16'd0);
      check("abort_after_busy",  {15'd0, fp_busy}, 16'd0);

      // Saturation: hold a load-use stall for 65534 edges, then 3 more.
      ex_mem_read = 1'b1; ex_dst = 5'd12; id_rs = 5'd12;
      repeat (65534) tick();
      check("sat_pre", stall_count, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("sat_hold", stall_count, 16'hFFFF);
      end
      clear_inputs();
      tick();
      check("sat_final", stall_count, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_hazard_unit
`default_nettype wire
